// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM states and iteration mode.
package muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  typedef enum logic {STEP_MUL, STEP_DIV} step_mode_e;

  function automatic logic is_div_op(logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_arith_op(logic [2:0] op);
    return op <= MD_DIVU;
  endfunction

  function automatic logic is_signed_op(logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 mode,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_next,
  output logic                 q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
  assign diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};

  // Divide: the shifted partial remainder is WIDTH+1 bits; no borrow means the bit is 1.
  always_comb begin
    acc_next = '0;
    q_bit    = 1'b0;
    if (mode == STEP_DIV) begin
      q_bit    = ~diff[WIDTH];
      acc_next = {(q_bit ? diff[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1]), acc[WIDTH-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers,
// start/busy/done handshake and flush abort.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned AW    = 2 * WIDTH;

  state_e           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    acc, step_acc;
  logic [WIDTH-1:0] opnd;
  step_mode_e       mode;
  logic             step_q, sign_q, sign_r, dz;
  logic             accept_md, accept_dz, we_hi, we_lo, iter, commit;
  logic             a_neg, b_neg, op_div;
  logic [WIDTH-1:0] a_mag, b_mag, res_hi, res_lo, quo, rem;
  logic [AW-1:0]    prod;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode     (mode),
    .acc      (acc),
    .operand  (opnd),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept_md  = 1'b0;
    accept_dz  = 1'b0;
    we_hi      = 1'b0;
    we_lo      = 1'b0;
    iter       = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          if (is_div_op(op) && (src_b == '0)) begin
            accept_dz  = 1'b1;
            state_next = FIX;
          end else if (is_arith_op(op)) begin
            accept_md  = 1'b1;
            state_next = CALC;
          end else if (op == MD_MTHI) begin
            we_hi = 1'b1;
          end else if (op == MD_MTLO) begin
            we_lo = 1'b1;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          iter = 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
        commit     = !flush;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand magnitudes and signs captured at accept.
  always_comb begin
    op_div = is_div_op(op);
    a_neg  = is_signed_op(op) & src_a[WIDTH-1];
    b_neg  = is_signed_op(op) & src_b[WIDTH-1];
    a_mag  = a_neg ? (WIDTH'(0) - src_a) : src_a;
    b_mag  = b_neg ? (WIDTH'(0) - src_b) : src_b;
  end

  // Sign fix-up of the unsigned result; most-negative / -1 wraps to itself naturally.
  always_comb begin
    prod = sign_q ? (AW'(0) - acc) : acc;
    quo  = sign_q ? (WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem  = sign_r ? (WIDTH'(0) - acc[AW-1:WIDTH]) : acc[AW-1:WIDTH];
    if (mode == STEP_DIV) begin
      res_hi = rem;
      res_lo = quo;
    end else begin
      res_hi = prod[AW-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      mode     <= STEP_MUL;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      dz       <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      busy     <= (state_next != IDLE);
      done     <= commit;
      div_zero <= commit & dz;
      if (accept_md) begin
        cnt    <= '0;
        mode   <= op_div ? STEP_DIV : STEP_MUL;
        opnd   <= op_div ? b_mag : a_mag;
        acc    <= {WIDTH'(0), (op_div ? a_mag : b_mag)};
        sign_q <= a_neg ^ b_neg;
        sign_r <= a_neg;
        dz     <= 1'b0;
      end
      // Divide by zero preloads the final HI/LO so FIX needs no special case.
      if (accept_dz) begin
        mode   <= STEP_DIV;
        acc    <= {src_a, {WIDTH{1'b1}}};
        sign_q <= 1'b0;
        sign_r <= 1'b0;
        dz     <= 1'b1;
      end
      if (iter) begin
        acc <= step_acc | AW'(step_q);
        cnt <= cnt + CNT_W'(1);
      end
      if (commit) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      if (we_hi) hi <= src_a;
      if (we_lo) lo <= src_a;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO/div_zero and
// completion cycle; a negedge monitor pops and compares on each done pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n, start, flush;
  logic [2:0]    op;
  logic [W-1:0]  src_a, src_b;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           due;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
        chk({e.name, "_divzero"}, W'(div_zero), W'(e.dz));
        chk({e.name, "_latency"}, W'(cyc), W'(e.due));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                       input string nm, input bit intrude);
    exp_t e;
    int   n;
    wait_idle();
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.hi = eh; e.lo = el; e.dz = edz; e.name = nm;
    e.due = cyc + (edz ? 1 : W + 1);
    sb.push_back(e);
    chk({nm, "_busy"}, W'(busy), W'(1));
    if (intrude) begin
      repeat (5) @(negedge clk);
      start = 1'b1; op = MD_MULTU; src_a = 32'd3; src_b = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 100 cycles", nm);
      sb.delete();
    end
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", hi, '0);
    chk("reset_lo", lo, '0);
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(MD_MULT,  32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_m7x3", 1'b0);
    do_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max", 1'b0);
    do_op(MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, "mult_m1xm1", 1'b0);
    do_op(MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, "multu_carry", 1'b0);
    do_op(MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7d2", 1'b0);
    do_op(MD_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0, "divu_7d2", 1'b1);
    do_op(MD_DIV,   32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b0, "div_100dm7", 1'b0);
    do_op(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_ovf", 1'b0);
    do_op(MD_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, "divu_by0", 1'b0);
    do_op(MD_DIV,   32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF, 1'b1, "div_by0", 1'b0);

    // MTHI, then a MULT aborted by flush must leave HI intact and raise no done.
    wait_idle();
    start = 1'b1; op = MD_MTHI; src_a = 32'h1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mthi_hi", hi, 32'h1234);
    @(negedge clk);
    start = 1'b1; op = MD_MTLO; src_a = 32'h5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h5678);
    @(negedge clk);
    start = 1'b1; op = MD_MULT; src_a = 32'd5; src_b = 32'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    d0 = done_cnt;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", W'(busy), '0);
    chk("flush_hi", hi, 32'h1234);
    chk("flush_lo", lo, 32'h5678);
    repeat (40) @(negedge clk);
    chk("flush_no_done", W'(done_cnt), W'(d0));

    // start together with flush in IDLE is dropped.
    start = 1'b1; flush = 1'b1; op = MD_MTHI; src_a = 32'hDEAD;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_hi", hi, 32'h1234);
    chk("idle_flush_busy", W'(busy), '0);

    // Reset mid-CALC clears everything.
    @(negedge clk);
    start = 1'b1; op = MD_MULTU; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_hi", hi, '0);
    chk("midreset_lo", lo, '0);
    chk("midreset_busy", W'(busy), '0);
    chk("midreset_done", W'(done), '0);
    chk("midreset_divzero", W'(div_zero), '0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, "divu_after_reset", 1'b0);
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit with architectural HI/LO registers. It sits beside the execute-stage ALU and owns all multi-cycle HI/LO arithmetic: signed and unsigned multiply, signed and unsigned divide, and direct HI/LO writes. A start/busy/done handshake lets the pipeline stall on HI/LO consumers while an operation runs. Operations can be aborted by flush without corrupting HI/LO.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits; must be ≥ 4 and even.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: request; sampled only in IDLE.
- `op` input 3: operation code (`MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`).
- `src_a` input WIDTH: multiplicand / dividend / MT data.
- `src_b` input WIDTH: multiplier / divisor.
- `flush` input 1: abort any in-flight operation.
- `busy` output 1: operation in progress; start is ignored while high.
- `done` output 1: one-cycle pulse, HI/LO just updated by a mult/div.
- `div_zero` output 1: one-cycle pulse with `done` when the divisor was 0.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- FSM states: IDLE, CALC, FIX.
  - IDLE→CALC on `start` with a mult/div op and a nonzero divisor for div.
  - IDLE→FIX on `start` with a div op and `src_b == 0`.
  - CALC→FIX after `WIDTH` iterations.
  - FIX→IDLE always.
- MTHI/MTLO: write `src_a` to HI/LO at the accepting edge. No state change, no `done`.
- Signed ops: take the absolute values of the operands at accept and record the result signs. Iterate unsigned. Apply the signs in FIX.
  - Quotient sign = `sign_a ^ sign_b`.
  - Remainder sign = `sign_a`, so the remainder truncates toward zero.
- MULT/MULTU: shift-add, one multiplier bit per CALC cycle, 2·WIDTH-bit accumulator. HI = upper half, LO = lower half.
- DIV/DIVU: restoring division, one quotient bit per CALC cycle. LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = `src_a` unchanged; `div_zero` pulses.
- Signed overflow (most-negative ÷ −1): LO = most-negative, HI = 0. This falls out of the magnitude arithmetic and needs no special path.
- HI/LO are written only at the FIX→IDLE edge or by MTHI/MTLO. Intermediate values never appear on `hi`/`lo`.
- `flush` in CALC/FIX: return to IDLE next edge, HI/LO unchanged, no `done`.
- `flush` in IDLE: the same-cycle `start` is ignored.
- `start` while `busy`: ignored, no queuing. The pipeline must stall.
- Reset: state IDLE; `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0. Reset mid-operation discards it. Reset has priority over `flush` and `start`.

## Timing
- `start` accepted at edge k (mult/div): `busy`=1 from k to k+WIDTH+1.
- Final CALC iteration at edge k+WIDTH.
- FIX at edge k+WIDTH+1: HI/LO updated, `busy` falls, `done` high for one cycle after that edge.
- Latency start→`done` is WIDTH+1 cycles (33 at default).
- Divide by zero: HI/LO updated and `done`/`div_zero` pulse at edge k+1. Latency is 1 cycle; `busy` is high for one cycle.
- A new `start` may be accepted in the same cycle that `done` is high. Back-to-back throughput is WIDTH+2 cycles per op.
- MTHI/MTLO: `hi`/`lo` visible one cycle after accept. Throughput is one per cycle.
- All outputs registered; no combinational input→output paths.

## Structure
- `muldiv_pkg`:
  - op encodings: `MD_MULT`=0, `MD_MULTU`=1, `MD_DIV`=2, `MD_DIVU`=3, `MD_MTHI`=4, `MD_MTLO`=5; codes 6–7 are no-ops.
  - state enum (IDLE/CALC/FIX).
- One sub-module, `muldiv_step`: a combinational single iteration. Inputs are mode, accumulator, and operand; outputs are the next accumulator and quotient bit. Keeping it separate lets a radix-4 variant replace it later.
- Top level holds the FSM, iteration counter (`$clog2(WIDTH+1)` bits), sign flags, and HI/LO registers.

## Test plan
- MULT −7 × 3: `done` 33 cycles after start; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: `hi`=0xFFFFFFFE, `lo`=0x00000001. Signed MULT of the same operands gives `hi`=0, `lo`=1.
- DIV −7 ÷ 2: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7 ÷ 2: `lo`=3, `hi`=1.
- DIV 0x80000000 ÷ 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- DIVU 5 ÷ 0: `done`+`div_zero` one cycle after accept; `lo`=0xFFFFFFFF, `hi`=5.
- MTHI 0x1234 then MULT started; `flush` at cycle 10 → `hi`=0x1234 retained, no `done`. A `start` issued while busy is ignored. `rst_n`=0 mid-CALC → all outputs 0 next edge.
